// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared types for the fetch redirect controller
//
// Purpose: word type, redirect source/state enums and redirect record.
// redirect_src_t is ordered by ascending priority so that a plain
// magnitude compare between two sources decides which one wins.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    JMP  = 2'd1,
    BR   = 2'd2,
    EX   = 2'd3
  } redirect_src_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } redirect_state_t;

  typedef struct packed {
    redirect_src_t src;
    word_t         addr;
  } redirect_t;

endpackage

// File: rtl/redirect_prio_arb.sv
// rtl/redirect_prio_arb.sv - fixed-priority redirect source select
//
// Purpose: picks the highest-priority active request (ex > br > jmp).
// Ports:
//   ex_req/ex_addr, br_req/br_addr, jmp_req/jmp_addr : request inputs
//   win : selected redirect (src=NONE when nothing is requested)
module redirect_prio_arb
  import rv32i_types_pkg::*;
(
  input  logic      ex_req,
  input  word_t     ex_addr,
  input  logic      br_req,
  input  word_t     br_addr,
  input  logic      jmp_req,
  input  word_t     jmp_addr,
  output redirect_t win
);

  always_comb begin
    win.src  = NONE;
    win.addr = '0;
    if (ex_req) begin
      win.src  = EX;
      win.addr = ex_addr;
    end else if (br_req) begin
      win.src  = BR;
      win.addr = br_addr;
    end else if (jmp_req) begin
      win.src  = JMP;
      win.addr = jmp_addr;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch-stage redirect/flush/stall sequencer
//
// Purpose: arbitrates trap/branch/jump redirects, holds a redirect while an
// instruction fetch is in flight, and enforces a flush window afterwards.
// Ports:
//   CLK, RST (async, active-high)
//   ex_req/ex_addr, br_req/br_addr, jmp_req/jmp_addr : redirect requests
//   imem_busy   : fetch bus transaction in flight
//   pipe_stall  : downstream stall request
//   update_pc   : load PC from update_addr this cycle
//   update_addr : redirect target, holds last value when update_pc=0
//   flush       : squash the fetch output register
//   stall       : hold fetch PC and output register
// Optional (macro FETCH_REDIRECT_STATS_EN):
//   redirect_cnt : count of update_pc pulses
//   wait_cnt     : count of cycles spent in WAIT
module fetch_redirect_ctrl
  import rv32i_types_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter word_t       RESET_PC     = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_req,
  input  logic [31:0] ex_addr,
  input  logic        br_req,
  input  logic [31:0] br_addr,
  input  logic        jmp_req,
  input  logic [31:0] jmp_addr,
  input  logic        imem_busy,
  input  logic        pipe_stall,
  output logic        update_pc,
  output logic [31:0] update_addr,
  output logic        flush,
  output logic        stall
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] wait_cnt
`endif
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam bit         USE_FLUSH  = (FLUSH_CYCLES > 1);

  redirect_state_t state;
  redirect_t       pend;
  redirect_t       win;
  redirect_t       tgt;
  logic [3:0]      cnt;
  word_t           last_addr;
  logic            in_flush;
  logic            apply;
  logic            latch;
  logic            stall_int;
  logic            flush_int;
  logic            override;

  // br/jmp seen during the flush window come from squashed instructions.
  assign in_flush = (state == FLUSH);

  redirect_prio_arb u_arb (
    .ex_req  (ex_req),
    .ex_addr (ex_addr),
    .br_req  (br_req & ~in_flush),
    .br_addr (br_addr),
    .jmp_req (jmp_req & ~in_flush),
    .jmp_addr(jmp_addr),
    .win     (win)
  );

  // Only a strictly higher-priority source may replace the pending one.
  assign override = (win.src > pend.src);

  always_comb begin
    apply     = 1'b0;
    latch     = 1'b0;
    stall_int = 1'b0;
    flush_int = 1'b0;
    tgt       = win;
    case (state)
      IDLE: begin
        if (win.src != NONE) begin
          flush_int = 1'b1;
          if (imem_busy) begin
            latch     = 1'b1;
            stall_int = 1'b1;
          end else begin
            apply = 1'b1;
          end
        end
      end
      WAIT: begin
        stall_int = 1'b1;
        flush_int = 1'b1;
        tgt       = override ? win : pend;
        if (imem_busy) latch = override;
        else           apply = 1'b1;
      end
      FLUSH: begin
        flush_int = 1'b1;
        if (win.src == EX) begin
          if (imem_busy) begin
            latch     = 1'b1;
            stall_int = 1'b1;
          end else begin
            apply = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs are forced to their reset values while RST is held.
  assign update_pc   = apply & ~RST;
  assign update_addr = update_pc ? tgt.addr : last_addr;
  assign flush       = flush_int & ~RST;
  assign stall       = (stall_int | pipe_stall) & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      pend      <= '{src: NONE, addr: '0};
      cnt       <= '0;
      last_addr <= RESET_PC;
    end else if (apply) begin
      last_addr <= tgt.addr;
      pend      <= '{src: NONE, addr: '0};
      if (USE_FLUSH) begin
        state <= FLUSH;
        cnt   <= FLUSH_INIT;
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end else if (latch) begin
      pend  <= win;
      state <= WAIT;
      cnt   <= '0;
    end else if (state == FLUSH) begin
      cnt <= cnt - 4'd1;
      if (cnt <= 4'd1) state <= IDLE;
    end
  end

`ifdef FETCH_REDIRECT_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      redirect_cnt <= '0;
      wait_cnt     <= '0;
    end else begin
      if (update_pc)     redirect_cnt <= redirect_cnt + 32'd1;
      if (state == WAIT) wait_cnt     <= wait_cnt + 32'd1;
    end
  end
`endif

endmodule
